// File: rtl/decode_stage.sv
// decode_stage: RV32 instruction decode with a registered output bundle.
// decoder_pkg holds the encodings shared by the decoder and its consumers.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   flush_i                   drop all held bundles
//   in_valid_i/in_ready_o     instruction handshake (instr_i, pc_i)
//   out_valid_o/out_ready_i   bundle handshake
//   out_pc_o ... mret_o       decoded bundle fields
//   illegal_instr_o           bundle holds an illegal instruction
//   ill_cnt_o                 saturating count of delivered illegal bundles

package decoder_pkg;
    localparam int unsigned ALU_OP_WIDTH = 4;

    localparam logic [1:0] OP_A_RS1  = 2'd0;
    localparam logic [1:0] OP_A_PC   = 2'd1;
    localparam logic [1:0] OP_A_ZERO = 2'd2;
    localparam logic [1:0] OP_A_ZIMM = 2'd3;

    localparam logic [2:0] OP_B_RS2   = 3'd0;
    localparam logic [2:0] OP_B_IMM_I = 3'd1;
    localparam logic [2:0] OP_B_IMM_S = 3'd2;
    localparam logic [2:0] OP_B_IMM_B = 3'd3;
    localparam logic [2:0] OP_B_IMM_U = 3'd4;
    localparam logic [2:0] OP_B_INCR  = 3'd5;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 4'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 4'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LT   = 4'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GE   = 4'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 4'd14;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 4'd15;

    localparam logic [2:0] CSR_NONE = 3'd0;
    localparam logic [2:0] CSR_RW   = 3'd1;
    localparam logic [2:0] CSR_RS   = 3'd2;
    localparam logic [2:0] CSR_RC   = 3'd3;

    // Load/store type equals funct3 so the LSU can use it unchanged.
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam logic [1:0] WB_EX_RESULT = 2'd0;
    localparam logic [1:0] WB_MEM_DATA  = 2'd1;
    localparam logic [1:0] WB_CSR       = 2'd2;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [1:0]              a_sel;
        logic [2:0]              b_sel;
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic [2:0]              csr_op;
        logic                    csr_we;
        logic                    mem_req;
        logic                    mem_we;
        logic [2:0]              mem_size;
        logic                    gpr_we;
        logic [1:0]              wb_sel;
        logic                    branch;
        logic                    jal;
        logic                    jalr;
        logic                    mret;
        logic                    illegal;
    } dec_t;
endpackage

module decode_stage import decoder_pkg::*; #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned SKID_EN   = 1,
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [31:0]             instr_i,
    input  logic [XLEN-1:0]         pc_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         out_pc_o,
    output logic [1:0]              a_sel_o,
    output logic [2:0]              b_sel_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [2:0]              csr_op_o,
    output logic                    csr_we_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [2:0]              mem_size_o,
    output logic                    gpr_we_o,
    output logic [1:0]              wb_sel_o,
    output logic                    branch_o,
    output logic                    jal_o,
    output logic                    jalr_o,
    output logic                    mret_o,
    output logic                    illegal_instr_o,
    output logic [ILL_CNT_W-1:0]    ill_cnt_o
);

    // Bit 0 = main register valid, bit 1 = skid entry occupied.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    dec_t       dec;
    logic       ill;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    function automatic logic [ALU_OP_WIDTH-1:0] alu_of_f3(input logic [2:0] f);
        case (f)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec = '0;
        ill = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI, OPC_AUIPC: begin
                    dec.a_sel  = (opcode == OPC_LUI) ? OP_A_ZERO : OP_A_PC;
                    dec.b_sel  = OP_B_IMM_U;
                    dec.gpr_we = 1'b1;
                end
                OPC_JAL, OPC_JALR: begin
                    // ALU produces the link address pc + 4.
                    dec.a_sel  = OP_A_PC;
                    dec.b_sel  = OP_B_INCR;
                    dec.gpr_we = 1'b1;
                    dec.jal    = (opcode == OPC_JAL);
                    dec.jalr   = (opcode == OPC_JALR);
                    if (opcode == OPC_JALR && f3 != 3'b000) ill = 1'b1;
                end
                OPC_BRANCH: begin
                    dec.b_sel  = OP_B_RS2;
                    dec.branch = 1'b1;
                    case (f3)
                        3'b000:  dec.alu_op = ALU_EQ;
                        3'b001:  dec.alu_op = ALU_NE;
                        3'b100:  dec.alu_op = ALU_LT;
                        3'b101:  dec.alu_op = ALU_GE;
                        3'b110:  dec.alu_op = ALU_LTU;
                        3'b111:  dec.alu_op = ALU_GEU;
                        default: ill = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    dec.b_sel    = OP_B_IMM_I;
                    dec.mem_req  = 1'b1;
                    dec.mem_size = f3;
                    dec.gpr_we   = 1'b1;
                    dec.wb_sel   = WB_MEM_DATA;
                    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
                end
                OPC_STORE: begin
                    dec.b_sel    = OP_B_IMM_S;
                    dec.mem_req  = 1'b1;
                    dec.mem_we   = 1'b1;
                    dec.mem_size = f3;
                    if (f3[2] || f3[1:0] == 2'b11) ill = 1'b1;
                end
                OPC_OP_IMM: begin
                    dec.b_sel  = OP_B_IMM_I;
                    dec.gpr_we = 1'b1;
                    dec.alu_op = alu_of_f3(f3);
                    if (f3 == 3'b001 && f7 != 7'b0) ill = 1'b1;
                    if (f3 == 3'b101) begin
                        if (f7 == 7'b0100000) dec.alu_op = ALU_SRA;
                        else if (f7 != 7'b0) ill = 1'b1;
                    end
                end
                OPC_OP: begin
                    dec.b_sel  = OP_B_RS2;
                    dec.gpr_we = 1'b1;
                    if (f7 == 7'b0) dec.alu_op = alu_of_f3(f3);
                    else if (f7 == 7'b0100000 && f3 == 3'b000) dec.alu_op = ALU_SUB;
                    else if (f7 == 7'b0100000 && f3 == 3'b101) dec.alu_op = ALU_SRA;
                    else ill = 1'b1;
                end
                OPC_MISC_MEM: begin
                    // fence is a no-op in an in-order core without caches.
                    if (f3 != 3'b000) ill = 1'b1;
                end
                OPC_SYSTEM: begin
                    if (f3 == 3'b000) begin
                        // Only mret is supported; ecall/ebreak trap as illegal.
                        if (instr_i == 32'h3020_0073) dec.mret = 1'b1;
                        else ill = 1'b1;
                    end else if (f3 == 3'b100) begin
                        ill = 1'b1;
                    end else begin
                        dec.a_sel  = f3[2] ? OP_A_ZIMM : OP_A_RS1;
                        dec.csr_op = {1'b0, f3[1:0]};
                        // Set/clear with rs1/zimm = 0 must not write the CSR.
                        dec.csr_we = (f3[1:0] == 2'b01) || (instr_i[19:15] != 5'd0);
                        dec.gpr_we = 1'b1;
                        dec.wb_sel = WB_CSR;
                    end
                end
                default: ill = 1'b1;
            endcase
        end
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    logic [1:0]           state_q, state_d;
    dec_t                 main_dec_q, main_dec_d, skid_dec_q, skid_dec_d;
    logic [XLEN-1:0]      main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic                 accept, deliver;

    assign out_valid_o = state_q[0];
    assign in_ready_o  = (SKID_EN != 0) ? ~state_q[1] : (~state_q[0] | out_ready_i);
    assign accept      = in_valid_i & in_ready_o;
    assign deliver     = out_valid_o & out_ready_i;

    always_comb begin
        state_d    = state_q;
        main_dec_d = main_dec_q;
        main_pc_d  = main_pc_q;
        skid_dec_d = skid_dec_q;
        skid_pc_d  = skid_pc_q;
        ill_cnt_d  = ill_cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_dec_d = dec;
                    main_pc_d  = pc_i;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    main_dec_d = dec;
                    main_pc_d  = pc_i;
                end else if (accept && SKID_EN != 0) begin
                    skid_dec_d = dec;
                    skid_pc_d  = pc_i;
                    state_d    = ST_TWO;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deliver) begin
                    main_dec_d = skid_dec_q;
                    main_pc_d  = skid_pc_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) state_d = ST_EMPTY;
        // Counting is tied to delivery, so a flush in the same cycle still counts.
        if (deliver && main_dec_q.illegal && !(&ill_cnt_q)) ill_cnt_d = ill_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            main_dec_q <= '0;
            main_pc_q  <= '0;
            skid_dec_q <= '0;
            skid_pc_q  <= '0;
            ill_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            main_dec_q <= main_dec_d;
            main_pc_q  <= main_pc_d;
            skid_dec_q <= skid_dec_d;
            skid_pc_q  <= skid_pc_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign out_pc_o        = main_pc_q;
    assign a_sel_o         = main_dec_q.a_sel;
    assign b_sel_o         = main_dec_q.b_sel;
    assign alu_op_o        = main_dec_q.alu_op;
    assign csr_op_o        = main_dec_q.csr_op;
    assign csr_we_o        = main_dec_q.csr_we;
    assign mem_req_o       = main_dec_q.mem_req;
    assign mem_we_o        = main_dec_q.mem_we;
    assign mem_size_o      = main_dec_q.mem_size;
    assign gpr_we_o        = main_dec_q.gpr_we;
    assign wb_sel_o        = main_dec_q.wb_sel;
    assign branch_o        = main_dec_q.branch;
    assign jal_o           = main_dec_q.jal;
    assign jalr_o          = main_dec_q.jalr;
    assign mret_o          = main_dec_q.mret;
    assign illegal_instr_o = main_dec_q.illegal;
    assign ill_cnt_o       = ill_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage (default build) plus a
// second instance with SKID_EN=0, ILL_CNT_W=2 sharing the same inputs.
module tb_decode_stage;
    import decoder_pkg::*;

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] MRET  = 32'h3020_0073;
    localparam logic [31:0] FENCE = 32'h0000_000F;
    localparam logic [31:0] SW    = 32'h0020_A023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr, pc;

    logic        in_ready, out_valid, csr_we, mem_req, mem_we, gpr_we;
    logic        branch, jal, jalr, mret, illegal;
    logic [31:0] out_pc;
    logic [1:0]  a_sel, wb_sel;
    logic [2:0]  b_sel, csr_op, mem_size;
    logic [3:0]  alu_op;
    logic [7:0]  ill_cnt;

    logic        in_ready2, out_valid2, csr_we2, mem_req2, mem_we2, gpr_we2;
    logic        branch2, jal2, jalr2, mret2, illegal2;
    logic [31:0] out_pc2;
    logic [1:0]  a_sel2, wb_sel2;
    logic [2:0]  b_sel2, csr_op2, mem_size2;
    logic [3:0]  alu_op2;
    logic [1:0]  ill_cnt2;

    decode_stage dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_pc_o(out_pc), .a_sel_o(a_sel), .b_sel_o(b_sel),
        .alu_op_o(alu_op), .csr_op_o(csr_op), .csr_we_o(csr_we), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_size_o(mem_size), .gpr_we_o(gpr_we), .wb_sel_o(wb_sel),
        .branch_o(branch), .jal_o(jal), .jalr_o(jalr), .mret_o(mret),
        .illegal_instr_o(illegal), .ill_cnt_o(ill_cnt)
    );

    decode_stage #(.XLEN(32), .SKID_EN(0), .ILL_CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready2), .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .out_pc_o(out_pc2), .a_sel_o(a_sel2), .b_sel_o(b_sel2),
        .alu_op_o(alu_op2), .csr_op_o(csr_op2), .csr_we_o(csr_we2), .mem_req_o(mem_req2),
        .mem_we_o(mem_we2), .mem_size_o(mem_size2), .gpr_we_o(gpr_we2), .wb_sel_o(wb_sel2),
        .branch_o(branch2), .jal_o(jal2), .jalr_o(jalr2), .mret_o(mret2),
        .illegal_instr_o(illegal2), .ill_cnt_o(ill_cnt2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ill_list [5];
        logic [1:0]  exp_cnt2 [5];
        ill_list = '{32'h0000_0000, 32'h0010_0073, 32'h0000_0073, 32'h0000_100F, 32'h4000_1033};
        exp_cnt2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_ill_cnt", 64'(ill_cnt), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        tick();
        rst = 1'b0;

        // addi x1,x0,5
        in_valid = 1'b1; instr = ADDI; pc = 32'h100; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_pc", 64'(out_pc), 64'h100);
        check("addi_a_sel", 64'(a_sel), 64'(OP_A_RS1));
        check("addi_b_sel", 64'(b_sel), 64'(OP_B_IMM_I));
        check("addi_alu", 64'(alu_op), 64'(ALU_ADD));
        check("addi_gpr_we", 64'(gpr_we), 64'd1);
        check("addi_wb_sel", 64'(wb_sel), 64'(WB_EX_RESULT));
        check("addi_illegal", 64'(illegal), 64'd0);
        tick();
        check("addi_drained", 64'(out_valid), 64'd0);

        // Illegal zero word followed by mret
        in_valid = 1'b1; instr = 32'h0; pc = 32'h200;
        tick();
        instr = MRET; pc = 32'h204;
        check("zero_illegal", 64'(illegal), 64'd1);
        check("zero_gpr_we", 64'(gpr_we), 64'd0);
        check("zero_cnt_pre", 64'(ill_cnt), 64'd0);
        tick();
        in_valid = 1'b0;
        check("zero_cnt_post", 64'(ill_cnt), 64'd1);
        check("mret_flag", 64'(mret), 64'd1);
        check("mret_illegal", 64'(illegal), 64'd0);
        check("mret_pc", 64'(out_pc), 64'h204);
        tick();
        check("mret_cnt", 64'(ill_cnt), 64'd1);

        // Skid buffer: three back-to-back offers while stalled
        out_ready = 1'b0; in_valid = 1'b1; instr = ADDI; pc = 32'h0;
        tick();
        pc = 32'h4;
        check("skid_ready_one", 64'(in_ready), 64'd1);
        check("noskid_ready_one", 64'(in_ready2), 64'd0);
        tick();
        pc = 32'h8;
        check("skid_ready_two", 64'(in_ready), 64'd0);
        tick();
        check("skid_hold_valid", 64'(out_valid), 64'd1);
        check("skid_hold_pc", 64'(out_pc), 64'h0);
        out_ready = 1'b1;
        tick();
        check("skid_order_4", 64'(out_pc), 64'h4);
        check("skid_ready_back", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("skid_order_8", 64'(out_pc), 64'h8);
        tick();
        check("skid_empty", 64'(out_valid), 64'd0);

        // Flush from TWO with an instruction offered
        out_ready = 1'b0; in_valid = 1'b1; pc = 32'h10;
        tick();
        pc = 32'h14;
        tick();
        check("flush_pre_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; pc = 32'h18;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        tick();
        check("flush_absent", 64'(out_valid), 64'd0);
        // Flush overrides an accept from EMPTY
        in_valid = 1'b1; pc = 32'h20; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_drop", 64'(out_valid), 64'd0);
        check("flush_cnt_keep", 64'(ill_cnt), 64'd1);
        // Delivery coinciding with a flush still counts
        in_valid = 1'b1; instr = 32'h0; pc = 32'h30;
        tick();
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_deliver_cnt", 64'(ill_cnt), 64'd2);
        check("flush_deliver_valid", 64'(out_valid), 64'd0);

        // fence is a legal no-op; sw decodes as a store word
        in_valid = 1'b1; instr = FENCE; pc = 32'h50;
        tick();
        instr = SW; pc = 32'h54;
        check("fence_illegal", 64'(illegal), 64'd0);
        check("fence_flags", 64'({gpr_we, mem_req, mem_we, csr_we}), 64'd0);
        tick();
        in_valid = 1'b0;
        check("sw_flags", 64'({gpr_we, mem_req, mem_we}), 64'b011);
        check("sw_size", 64'(mem_size), 64'(LDST_W));
        check("sw_b_sel", 64'(b_sel), 64'(OP_B_IMM_S));
        tick();

        // Asynchronous reset mid-cycle while holding a bundle
        out_ready = 1'b0; in_valid = 1'b1; instr = ADDI; pc = 32'h40;
        tick();
        in_valid = 1'b0;
        check("prerst_valid", 64'(out_valid), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_pc", 64'(out_pc), 64'd0);
        check("arst_gpr_we", 64'(gpr_we), 64'd0);
        check("arst_cnt", 64'(ill_cnt), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        #2 rst = 1'b0;
        tick();
        in_valid = 1'b1; instr = ADDI; pc = 32'h44; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("postrst_valid", 64'(out_valid), 64'd1);
        check("postrst_pc", 64'(out_pc), 64'h44);
        tick();

        // Saturating counter: ILL_CNT_W=2 on dut2, 8 bits on dut
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            instr = ill_list[k]; pc = 32'h60 + 32'(4 * k);
            tick();
            check($sformatf("ill_%0d_flag", k), 64'(illegal), 64'd1);
            check($sformatf("ill_%0d_gpr", k), 64'(gpr_we), 64'd0);
            if (k >= 1) begin
                check($sformatf("sat_cnt_%0d", k), 64'(ill_cnt2), 64'(exp_cnt2[k-1]));
                check($sformatf("wide_cnt_%0d", k), 64'(ill_cnt), 64'(k));
            end
        end
        in_valid = 1'b0;
        tick();
        check("sat_cnt_5", 64'(ill_cnt2), 64'(exp_cnt2[4]));
        check("wide_cnt_5", 64'(ill_cnt), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
